// File: rtl/window_gen_55.sv
// 5x5 sliding-window generator over a zero-padded (D+4)x(D+4) raster stream.
// Optional build macro WINGEN_SKIP_LEAD_EN: drop the first beat of every frame.
module window_gen_55 #(
    parameter int unsigned D          = 35,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid_in,
    input  logic [DATA_WIDTH-1:0]        pxl_in,
    output logic [25*DATA_WIDTH-1:0]     win_out,
    output logic                         valid_out,
    output logic [$clog2(D)-1:0]         out_row,
    output logic [$clog2(D)-1:0]         out_col,
    output logic                         frame_done
);

    localparam int unsigned W  = D + 4;
    localparam int unsigned CW = $clog2(W);
    localparam int unsigned OW = $clog2(D);
    localparam int unsigned K  = 5;

    logic [CW-1:0]         row;
    logic [CW-1:0]         col;
    logic                  accept;
    logic                  last_col;
    logic                  last_row;
    logic                  frame_end;
    logic                  win_ready;
    logic [DATA_WIDTH-1:0] lb       [4][W];
    logic [DATA_WIDTH-1:0] hist     [K][K-1];
    logic [DATA_WIDTH-1:0] new_col  [K];

    assign last_col  = (col == CW'(W - 1));
    assign last_row  = (row == CW'(W - 1));
    assign win_ready = (row >= CW'(K - 1)) && (col >= CW'(K - 1));
    assign frame_end = accept && last_row && last_col;

`ifdef WINGEN_SKIP_LEAD_EN
    // Set once the padding stage's extra leading beat of a frame has been swallowed.
    logic lead_skipped;

    assign accept = valid_in && lead_skipped;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lead_skipped <= 1'b0;
        end else if (frame_end) begin
            lead_skipped <= 1'b0;
        end else if (valid_in && !lead_skipped) begin
            lead_skipped <= 1'b1;
        end
    end
`else
    assign accept = valid_in;
`endif

    // Raster position of the beat being accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + CW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffers carry no reset: every entry is rewritten before a window can use it.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb[3][col] <= lb[2][col];
            lb[2][col] <= lb[1][col];
            lb[1][col] <= lb[0][col];
            lb[0][col] <= pxl_in;
        end
    end

    // Incoming column, oldest row on top.
    always_comb begin
        new_col[0] = lb[3][col];
        new_col[1] = lb[2][col];
        new_col[2] = lb[1][col];
        new_col[3] = lb[0][col];
        new_col[4] = pxl_in;
    end

    // hist keeps the four most recent columns; win_out only loads on a complete window
    // so it holds steady through row lead-in and gaps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < int'(K); r++) begin
                for (int c = 0; c < int'(K - 1); c++) begin
                    hist[r][c] <= '0;
                end
            end
            win_out    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
        end else begin
            valid_out  <= accept && win_ready;
            frame_done <= frame_end;
            if (accept) begin
                for (int r = 0; r < int'(K); r++) begin
                    for (int c = 0; c < int'(K - 2); c++) begin
                        hist[r][c] <= hist[r][c+1];
                    end
                    hist[r][K-2] <= new_col[r];
                end
                if (win_ready) begin
                    for (int r = 0; r < int'(K); r++) begin
                        for (int c = 0; c < int'(K - 1); c++) begin
                            win_out[(r*5+c)*DATA_WIDTH +: DATA_WIDTH] <= hist[r][c];
                        end
                        win_out[(r*5+4)*DATA_WIDTH +: DATA_WIDTH] <= new_col[r];
                    end
                    out_row <= OW'(row - CW'(K - 1));
                    out_col <= OW'(col - CW'(K - 1));
                end
            end
        end
    end

endmodule

// File: doc/window_gen_55.md
Name: window_gen_55

Overview:
- Consumes the zero-padded pixel stream from the 5x5 padding stage: (D+4)x(D+4) pixels, raster order, one pixel per valid beat.
- Buffers four previous padded rows and a 5x5 register window.
- Emits one complete 5x5 neighbourhood per beat for every output position of a 5x5 "valid" convolution, producing D x D windows per frame.
- Feeds the 5x5 MAC / convolution core directly.

Parameters:
- D, 35, unpadded image side; padded side W = D+4 (localparam).
- DATA_WIDTH, 32, pixel width in bits.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  1  pxl_in carries a padded-stream pixel this cycle.
- pxl_in  in  DATA_WIDTH  padded pixel, raster order.
- win_out  out  25*DATA_WIDTH  window; element k = r*5+c (r=0 top row, c=0 left column) at bits [k*DATA_WIDTH +: DATA_WIDTH].
- valid_out  out  1  win_out holds a complete window this cycle.
- out_row  out  $clog2(D)  output-plane row of the current window (0..D-1).
- out_col  out  $clog2(D)  output-plane column of the current window (0..D-1).
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset: asynchronous, active-high, wins over everything including mid-frame. Clears:
  - counters row/col,
  - valid_out, frame_done, out_row, out_col,
  - all window registers (win_out = 0).
  - Line-buffer contents need not be cleared; they are never exposed before being rewritten.
- Counters:
  - col runs 0..W-1, row runs 0..W-1.
  - Advance only on valid_in: col increments; at col = W-1, col wraps to 0 and row increments.
  - At row = W-1, col = W-1, both wrap to 0 and frame_done pulses on the next cycle.
- Line buffers: four arrays LB0..LB3, W entries each, addressed by col. LB0 holds the previous row, LB3 the row four back.
- Beat accepted at (row, col):
  - New column, top to bottom = {LB3[col], LB2[col], LB1[col], LB0[col], pxl_in}.
  - Update LB3[col] <= LB2[col], LB2 <= LB1, LB1 <= LB0, LB0 <= pxl_in, all in the same cycle.
  - Window shifts one column left; the new column enters at c=4.
- Output:
  - Registered; latency is 1 cycle.
  - valid_out = 1 in the cycle after a beat accepted with row >= 4 and col >= 4.
  - That window covers padded rows row-4..row and columns col-4..col.
  - out_row = row-4 and out_col = col-4, updated together with valid_out.
  - win_out holds its value when valid_out = 0.
- Gaps: valid_in = 0 freezes the counters, window and buffers. valid_out = 0 in the following cycle.
- No backpressure: every valid_in beat is accepted. Downstream must accept every valid_out.
- Frame boundary:
  - A new frame may start in the cycle immediately after the last beat (back-to-back).
  - Windows do not mix frames: rows 0-3 of a frame never produce output, and LB contents are overwritten before use.
  - frame_done and valid_out (for the final window) assert in the same cycle.
- Per-frame totals: exactly D*D valid_out pulses and one frame_done per W*W accepted beats.

Optional Feature:
- Macro: WINGEN_SKIP_LEAD_EN.
- Defined:
  - The first valid_in beat after reset, and the first after each frame_done, is discarded: not stored, not counted.
  - This absorbs the padding stage's extra leading beat; a frame is then W*W+1 beats.
  - A 1-bit "lead skipped" flag is cleared by reset and by frame completion.
- Undefined: every valid_in beat is part of the frame; a frame is exactly W*W beats.

Test Plan:
- Ramp, D=3 (W=7): stream of 49 contiguous beats, pxl_in = beat index 0..48.
  - First valid_out one cycle after beat 32, with win_out[0]=0, win_out[4]=4, win_out[20]=28, win_out[24]=32, out_row=0, out_col=0.
  - Exactly 9 valid_out pulses.
  - Last window: win_out[24]=48, out_row=2, out_col=2, with frame_done in the same cycle.
- Bubbles: same ramp with valid_in toggling 1-0 every beat → identical 9 windows and values. valid_out is never asserted in a cycle following valid_in=0.
- Back-to-back frames: second frame, pxl_in = 100+index, immediately follows the first.
  - 18 windows total.
  - First window of frame 2: win_out[0]=100, win_out[24]=132. No frame-1 values appear.
- Reset mid-frame: assert reset after beat 40 of a frame.
  - valid_out, frame_done and win_out drop to 0 immediately (asynchronous).
  - A fresh 49-beat ramp then yields the same results as the Ramp scenario.
- D=35 default: 1521 beats → 1225 valid_out pulses and one frame_done.
  - First window at beat index 4*39+4=160.
  - out_row/out_col sweep 0..34 in raster order.
- Macro WINGEN_SKIP_LEAD_EN defined, D=3: 50 beats; beat 0 = 0xDEAD, then the ramp 0..48.
  - Results identical to the Ramp scenario; 0xDEAD never appears in win_out.
